// File: rtl/sync_key.sv
// Keypad front end: registers the raw key lines, encodes the highest pressed key,
// and emits a one-cycle strobe plus a two-deep nibble history per new press.
module sync_key (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] in,
    output logic [4:0]  out,
    output logic        strobe,
    output logic [3:0]  reg1,
    output logic [3:0]  reg2
);

    logic [16:0] in_q;
    logic        any;
    logic        any_d;
    logic        press;
    logic [4:0]  enc;

    // Highest set bit wins when several keys are held together.
    always_comb begin
        enc = '0;
        for (int i = 0; i < 17; i++) begin
            if (in_q[i]) begin
                enc = 5'(i);
            end
        end
    end

    assign any   = |in_q;
    assign press = any & ~any_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_q  <= '0;
            any_d <= 1'b0;
        end else begin
            in_q  <= in;
            any_d <= any;
        end
    end

    // out tracks any held key; strobe and history move only on a fresh press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out    <= '0;
            strobe <= 1'b0;
            reg1   <= '0;
            reg2   <= '0;
        end else begin
            if (any) begin
                out <= enc;
            end
            strobe <= press;
            if (press) begin
                reg2 <= reg1;
                reg1 <= enc[3:0];
            end
        end
    end

endmodule

// File: tb/tb_sync_key.sv
// Scoreboard bench for sync_key: presses push expected (out, reg1, reg2) tuples,
// a monitor pops one on every strobe; directed checks cover hold, reset and key changes.
module tb_sync_key;

    logic        clk;
    logic        rst;
    logic [16:0] in;
    logic [4:0]  out;
    logic        strobe;
    logic [3:0]  reg1;
    logic [3:0]  reg2;

    typedef struct packed {
        logic [4:0] out;
        logic [3:0] r1;
        logic [3:0] r2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    sync_key dut (
        .clk    (clk),
        .rst    (rst),
        .in     (in),
        .out    (out),
        .strobe (strobe),
        .reg1   (reg1),
        .reg2   (reg2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [4:0] actual, input logic [4:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic push_exp(input logic [4:0] o, input logic [3:0] r1, input logic [3:0] r2);
        exp_t e;
        e.out = o;
        e.r1  = r1;
        e.r2  = r2;
        exp_q.push_back(e);
    endtask

    // Drive a vector on a falling edge and hold it for the given number of cycles.
    task automatic apply_stimulus(input logic [16:0] vec, input int cycles);
        @(negedge clk);
        in = vec;
        repeat (cycles) @(negedge clk);
    endtask

    // Monitor: every strobe must match the oldest outstanding press.
    always @(negedge clk) begin
        if (rst && strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_strobe: strobe=1 with no press pending, out=%0d at %0t", out, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("strobe_out", out, e.out);
                check_output("strobe_reg1", {1'b0, reg1}, {1'b0, e.r1});
                check_output("strobe_reg2", {1'b0, reg2}, {1'b0, e.r2});
            end
        end
    end

    initial begin
        rst = 1'b0;
        in  = '0;
        #1;
        check_output("por_out", out, 5'd0);
        check_output("por_strobe", {4'd0, strobe}, 5'd0);
        check_output("por_reg1", {1'b0, reg1}, 5'd0);
        check_output("por_reg2", {1'b0, reg2}, 5'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_output("idle_out", out, 5'd0);
        check_output("idle_strobe", {4'd0, strobe}, 5'd0);

        // Sweep single-cycle presses of keys 1..16.
        for (int i = 1; i <= 16; i++) begin
            logic [4:0] k;
            logic [4:0] kp;
            k  = 5'(i);
            kp = 5'(i - 1);
            push_exp(k, k[3:0], (i == 1) ? 4'd0 : kp[3:0]);
            apply_stimulus(17'(1) << i, 1);
            in = '0;
            @(negedge clk);
            check_output("sweep_out", out, k);
            repeat (2) @(negedge clk);
            check_output("sweep_hold", out, k);
        end

        // History: 3, then 7, then 16.
        push_exp(5'd3, 4'd3, 4'd0);
        apply_stimulus(17'h00008, 2);
        check_output("hist3_out", out, 5'd3);
        apply_stimulus(17'h00000, 2);
        push_exp(5'd7, 4'd7, 4'd3);
        apply_stimulus(17'h00080, 2);
        check_output("hist7_reg1", {1'b0, reg1}, 5'd7);
        check_output("hist7_reg2", {1'b0, reg2}, 5'd3);
        apply_stimulus(17'h00000, 2);
        push_exp(5'd16, 4'd0, 4'd7);
        apply_stimulus(17'h10000, 2);
        check_output("hist16_out", out, 5'd16);
        check_output("hist16_reg1", {1'b0, reg1}, 5'd0);
        check_output("hist16_reg2", {1'b0, reg2}, 5'd7);
        apply_stimulus(17'h00000, 2);

        // Held key 5 across a mid-operation reset.
        push_exp(5'd5, 4'd5, 4'd0);
        apply_stimulus(17'h00020, 2);
        check_output("held_out", out, 5'd5);
        repeat (3) @(negedge clk);
        check_output("held_stable", out, 5'd5);
        #2;
        rst = 1'b0;
        #1;
        check_output("rst_out", out, 5'd0);
        check_output("rst_strobe", {4'd0, strobe}, 5'd0);
        check_output("rst_reg1", {1'b0, reg1}, 5'd0);
        check_output("rst_reg2", {1'b0, reg2}, 5'd0);
        @(negedge clk);
        push_exp(5'd5, 4'd5, 4'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_output("rerel_out", out, 5'd5);
        apply_stimulus(17'h00000, 2);

        // Two keys at once, then slide to another key with no gap.
        push_exp(5'd9, 4'd9, 4'd5);
        apply_stimulus(17'h00204, 2);
        check_output("multi_out", out, 5'd9);
        apply_stimulus(17'h00010, 2);
        check_output("slide_out", out, 5'd4);
        check_output("slide_reg1", {1'b0, reg1}, 5'd9);
        check_output("slide_reg2", {1'b0, reg2}, 5'd5);
        apply_stimulus(17'h00000, 2);

        // Key 0 after key 5.
        push_exp(5'd5, 4'd5, 4'd9);
        apply_stimulus(17'h00020, 2);
        apply_stimulus(17'h00000, 2);
        push_exp(5'd0, 4'd0, 4'd5);
        apply_stimulus(17'h00001, 2);
        check_output("key0_out", out, 5'd0);
        check_output("key0_reg2", {1'b0, reg2}, 5'd5);
        apply_stimulus(17'h00000, 2);

        // Bounded drain of the scoreboard.
        for (int n = 0; n < 20 && exp_q.size() > 0; n++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_strobe: %0d presses pending, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
